// File: rtl/risc_v_rf_mp.sv
// risc_v_rf_mp: multi-port register file with issue scoreboard; define RF_BYPASS_EN for write-to-read bypass
module risc_v_rf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD = 2,
    parameter int NWR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    waddr,
    input  logic [NWR*DATA_W-1:0]    wdata,
    input  logic [NRD-1:0]           re,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    output logic [NRD-1:0]           rbusy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy
);
    localparam int NREG = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [NREG];
    logic [DATA_W-1:0] mem_n [NREG];
    logic [NREG-1:0] busy_n;
    logic [NRD*DATA_W-1:0] rdata_n;
    logic [NRD-1:0] rbusy_n;
    // ascending port order lets the highest-numbered write win; reserve is applied last so it beats a clear
    always_comb begin
        mem_n = mem;
        busy_n = busy;
        for (int p = 0; p < NWR; p++)
            if (we[p] && waddr[p*ADDR_W +: ADDR_W] != '0) begin
                mem_n[waddr[p*ADDR_W +: ADDR_W]] = wdata[p*DATA_W +: DATA_W];
                busy_n[waddr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        if (rsv_en && rsv_addr != '0)
            busy_n[rsv_addr] = 1'b1;
    end
    always_comb begin
        rdata_n = '0;
        rbusy_n = '0;
        for (int k = 0; k < NRD; k++) begin
            rdata_n[k*DATA_W +: DATA_W] = mem[raddr[k*ADDR_W +: ADDR_W]];
            rbusy_n[k] = busy[raddr[k*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
            for (int p = 0; p < NWR; p++)
                if (we[p] && waddr[p*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W]) begin
                    rdata_n[k*DATA_W +: DATA_W] = wdata[p*DATA_W +: DATA_W];
                    rbusy_n[k] = rsv_en && rsv_addr == raddr[k*ADDR_W +: ADDR_W];
                end
`endif
            if (!re[k] || raddr[k*ADDR_W +: ADDR_W] == '0) begin
                rdata_n[k*DATA_W +: DATA_W] = '0;
                rbusy_n[k] = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
            busy <= '0;
            rdata <= '0;
            rbusy <= '0;
        end else begin
            mem <= mem_n;
            busy <= busy_n;
            rdata <= rdata_n;
            rbusy <= rbusy_n;
        end
    end
endmodule

// File: tb/tb_risc_v_rf_mp.sv
// tb_risc_v_rf_mp: randomized scoreboard bench for risc_v_rf_mp against an array-level reference model
module tb_risc_v_rf_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NREG = 1 << AW;
    typedef struct {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0] rbusy;
        logic [NREG-1:0] busy;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NW-1:0] we = '0;
    logic [NW*AW-1:0] waddr = '0;
    logic [NW*DW-1:0] wdata = '0;
    logic [NR-1:0] re = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0] rbusy;
    logic rsv_en = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    logic [NREG-1:0] busy;
    exp_t q[$];
    logic [DW-1:0] m_mem [NREG];
    logic [NREG-1:0] m_busy;
    int total = 0;
    int bad = 0;
    risc_v_rf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );
    always #5 clk = ~clk;
    // the model works on whole-cycle semantics: old state, then the state after all writes and the reserve
    task automatic issue(input logic rst, input logic [NW-1:0] w_e, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                         input logic [AW-1:0] wa1, input logic [DW-1:0] wd1, input logic [NR-1:0] r_e,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic rs_e, input logic [AW-1:0] rs_a);
        logic [DW-1:0] nm [NREG];
        logic [NREG-1:0] nb;
        logic [NREG-1:0] wr;
        logic [AW-1:0] wa [NW];
        logic [DW-1:0] wd [NW];
        logic [AW-1:0] ra [NR];
        exp_t e;
        @(negedge clk);
        reset = rst;
        we = w_e;
        waddr = {wa1, wa0};
        wdata = {wd1, wd0};
        re = r_e;
        raddr = {ra1, ra0};
        rsv_en = rs_e;
        rsv_addr = rs_a;
        wa = '{wa0, wa1};
        wd = '{wd0, wd1};
        ra = '{ra0, ra1};
        e.rdata = '0;
        e.rbusy = '0;
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_mem[i] = '0;
            m_busy = '0;
            e.busy = '0;
        end else begin
            nm = m_mem;
            nb = m_busy;
            wr = '0;
            for (int p = 0; p < NW; p++)
                if (w_e[p] && wa[p] != 0) begin
                    nm[wa[p]] = wd[p];
                    nb[wa[p]] = 1'b0;
                    wr[wa[p]] = 1'b1;
                end
            if (rs_e && rs_a != 0) nb[rs_a] = 1'b1;
            for (int k = 0; k < NR; k++)
                if (r_e[k] && ra[k] != 0) begin
`ifdef RF_BYPASS_EN
                    e.rdata[k*DW +: DW] = wr[ra[k]] ? nm[ra[k]] : m_mem[ra[k]];
                    e.rbusy[k] = wr[ra[k]] ? nb[ra[k]] : m_busy[ra[k]];
`else
                    e.rdata[k*DW +: DW] = m_mem[ra[k]];
                    e.rbusy[k] = m_busy[ra[k]];
`endif
                end
            m_mem = nm;
            m_busy = nb;
            e.busy = nb;
        end
        q.push_back(e);
    endtask
    function automatic void check(input exp_t e);
        total += 3;
        if (rdata !== e.rdata) begin
            bad++;
            $display("FAIL rdata t=%0t got=%h want=%h", $time, rdata, e.rdata);
        end
        if (rbusy !== e.rbusy) begin
            bad++;
            $display("FAIL rbusy t=%0t got=%b want=%b", $time, rbusy, e.rbusy);
        end
        if (busy !== e.busy) begin
            bad++;
            $display("FAIL busy t=%0t got=%h want=%h", $time, busy, e.busy);
        end
    endfunction
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) check(q.pop_front());
    end
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        issue(1, 2'b11, 5, 32'h1, 6, 32'h2, 2'b11, 5, 5, 1, 5);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 5, 5, 0, 0);
        issue(0, 2'b01, 0, 32'hDEADBEEF, 0, 0, 2'b11, 0, 0, 1, 0);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 0);
        issue(0, 2'b11, 7, 32'h11, 7, 32'h22, 2'b00, 0, 0, 0, 0);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 7, 7, 0, 0);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3);
        issue(0, 2'b01, 3, 32'h55, 0, 0, 2'b01, 3, 0, 0, 0);
        issue(0, 2'b10, 0, 0, 3, 32'h66, 2'b11, 3, 3, 1, 3);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 1, 3);
        issue(0, 2'b01, 9, 32'h1, 0, 0, 2'b00, 0, 0, 1, 9);
        issue(0, 2'b01, 9, 32'hA5A5A5A5, 0, 0, 2'b11, 9, 0, 0, 0);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 1, 9);
        issue(0, 2'b10, 0, 0, 9, 32'h77, 2'b11, 9, 9, 1, 9);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b01, 9, 9, 0, 0);
        issue(1, 2'b11, 9, 32'h99, 3, 32'h33, 2'b11, 9, 3, 1, 4);
        issue(0, 2'b00, 0, 0, 0, 0, 2'b11, 9, 3, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            logic big;
            big = $urandom_range(0, 7) == 0;
            issue($urandom_range(0, 63) == 0, NW'($urandom),
                  AW'(big ? $urandom_range(0, 31) : $urandom_range(0, 7)), $urandom(),
                  AW'(big ? $urandom_range(0, 31) : $urandom_range(0, 7)), $urandom(),
                  NR'($urandom_range(0, 3) == 0 ? $urandom : 3),
                  AW'(big ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                  AW'(big ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
        end
        @(negedge clk);
        we = '0;
        re = '0;
        rsv_en = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
